// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: issues one fetch at a time to instruction
// memory, returns each word with its PC to decode and handles redirects
// (exception > jump > branch) by retargeting the PC and discarding a
// response that is already in flight.
module fetch_sequencer #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        exception,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    typedef enum logic [1:0] {
        S_REQ = 2'd0,
        S_RSP = 2'd1,
        S_OUT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic        r_kill;
    logic        w_kill_nxt;
    logic        w_load;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic        w_redir;
    logic [31:0] w_target;
    logic        w_hs;

    // Request is held low while reset is asserted so nothing is issued during reset.
    assign imem_req_valid = (r_state == S_REQ) && reset;
    assign imem_req_addr  = r_pc;
    assign instr_valid    = (r_state == S_OUT);
    assign instr          = r_instr;
    assign instr_pc       = r_instr_pc;

    assign w_hs    = imem_req_valid && imem_req_ready;
    assign w_redir = exception || jump || branch_taken;

    // Select redirect destination by priority and force word alignment.
    always_comb begin
        w_target = branch_target;
        if (exception) begin
            w_target = EXC_VECTOR;
        end else if (jump) begin
            w_target = jump_target;
        end
        w_target[1:0] = 2'b00;
    end

    // Next-state, next-PC and kill-flag logic.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_kill_nxt  = r_kill;
        w_load      = 1'b0;
        case (r_state)
            S_REQ: begin
                if (w_hs) begin
                    w_state_nxt = S_RSP;
                    // Request accepted with the old address: its data must be dropped.
                    w_kill_nxt  = w_redir;
                end
                if (w_redir) begin
                    w_pc_nxt = w_target;
                end
            end
            S_RSP: begin
                if (w_redir) begin
                    w_pc_nxt = w_target;
                    if (imem_rsp_valid) begin
                        w_kill_nxt  = 1'b0;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_kill_nxt = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (r_kill) begin
                        w_kill_nxt  = 1'b0;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_load      = 1'b1;
                        w_state_nxt = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (w_redir) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = S_REQ;
                end else if (!stall) begin
                    w_pc_nxt    = r_pc + 32'd4;
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_REQ;
            end
        endcase
    end

    // State, PC, kill flag and decode-side output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_REQ;
            r_pc       <= RESET_ADDR;
            r_kill     <= 1'b0;
            r_instr    <= '0;
            r_instr_pc <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_kill  <= w_kill_nxt;
            if (w_load) begin
                r_instr    <= imem_rsp_data;
                r_instr_pc <= r_pc;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: scenario tasks with a scoreboard
// queue of expected (pc, instruction) pairs.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = '0;
    logic        exception = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   chk_cnt = 0;
    int   pass_cnt = 0;

    fetch_sequencer #(
        .RESET_ADDR(32'h0000_0000),
        .EXC_VECTOR(32'h8000_0180)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .exception     (exception),
        .imem_req_valid(imem_req_valid),
        .imem_req_addr (imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled at the negedge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Accept the pending request at exp_addr and return data one cycle later.
    task automatic fetch_one(input logic [31:0] exp_addr, input logic [31:0] data);
        exp_t x;
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        x.pc = exp_addr;
        x.data = data;
        exp_q.push_back(x);
        step();
        imem_rsp_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        chk_cnt++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0)
            $display("FAIL reset_valids: req_valid=%b instr_valid=%b want 0/0", imem_req_valid, instr_valid);
        else pass_cnt++;
        chk_cnt++;
        if (imem_req_addr !== 32'h0 || instr !== 32'h0 || instr_pc !== 32'h0)
            $display("FAIL reset_data: addr=%h instr=%h pc=%h want 0", imem_req_addr, instr, instr_pc);
        else pass_cnt++;
        reset = 1'b1;
        #1;
        chk_cnt++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0)
            $display("FAIL first_req: valid=%b addr=%h want 1/00000000", imem_req_valid, imem_req_addr);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        step();
        chk_cnt++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0)
            $display("FAIL req_hold: valid=%b addr=%h want 1/00000000", imem_req_valid, imem_req_addr);
        else pass_cnt++;
        fetch_one(32'h0, 32'h2000_0001);
        chk_cnt++;
        if (exp_q.size() == 0) begin
            $display("FAIL basic_pop: scoreboard empty want 1 entry");
        end else begin
            e = exp_q.pop_front();
            if (instr_valid !== 1'b1 || instr !== e.data || instr_pc !== e.pc)
                $display("FAIL basic_instr: v=%b instr=%h pc=%h want 1/%h/%h", instr_valid, instr, instr_pc, e.data, e.pc);
            else pass_cnt++;
        end
        stall = 1'b0;
        step();
        chk_cnt++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4 || instr_valid !== 1'b0)
            $display("FAIL next_req: valid=%b addr=%h iv=%b want 1/00000004/0", imem_req_valid, imem_req_addr, instr_valid);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        logic [31:0] hi;
        logic [31:0] hp;
        fetch_one(32'h4, 32'hCAFE_0004);
        e = exp_q.pop_front();
        hi = e.data;
        hp = e.pc;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_cnt++;
            if (instr_valid !== 1'b1 || instr !== hi || instr_pc !== hp || imem_req_valid !== 1'b0)
                $display("FAIL stall_hold%0d: v=%b instr=%h pc=%h req=%b want 1/%h/%h/0", i, instr_valid, instr, instr_pc, imem_req_valid, hi, hp);
            else pass_cnt++;
        end
        stall = 1'b0;
        step();
        chk_cnt++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8 || instr_valid !== 1'b0)
            $display("FAIL stall_release: valid=%b addr=%h iv=%b want 1/00000008/0", imem_req_valid, imem_req_addr, instr_valid);
        else pass_cnt++;
    endtask

    task automatic test_branch_in_rsp();
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0103;
        step();
        branch_taken = 1'b0;
        chk_cnt++;
        if (imem_req_valid !== 1'b0)
            $display("FAIL kill_wait: req_valid=%b want 0", imem_req_valid);
        else pass_cnt++;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_0008;
        step();
        imem_rsp_valid = 1'b0;
        chk_cnt++;
        if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100)
            $display("FAIL branch_rsp: iv=%b valid=%b addr=%h want 0/1/00000100", instr_valid, imem_req_valid, imem_req_addr);
        else pass_cnt++;
    endtask

    task automatic test_redirects();
        fetch_one(32'h100, 32'h1111_0100);
        chk_cnt++;
        e = exp_q.pop_front();
        if (instr_valid !== 1'b1 || instr !== e.data || instr_pc !== e.pc)
            $display("FAIL prio_instr: v=%b instr=%h pc=%h want 1/%h/%h", instr_valid, instr, instr_pc, e.data, e.pc);
        else pass_cnt++;
        stall = 1'b1;
        exception = 1'b1;
        jump = 1'b1;
        jump_target = 32'h200;
        branch_taken = 1'b1;
        branch_target = 32'h300;
        step();
        exception = 1'b0;
        jump = 1'b0;
        branch_taken = 1'b0;
        stall = 1'b0;
        chk_cnt++;
        if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0180)
            $display("FAIL prio_exc: iv=%b valid=%b addr=%h want 0/1/80000180", instr_valid, imem_req_valid, imem_req_addr);
        else pass_cnt++;
        jump = 1'b1;
        jump_target = 32'h42;
        step();
        jump = 1'b0;
        chk_cnt++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40)
            $display("FAIL req_redirect: valid=%b addr=%h want 1/00000040", imem_req_valid, imem_req_addr);
        else pass_cnt++;
        imem_req_ready = 1'b1;
        branch_taken = 1'b1;
        branch_target = 32'h1000;
        step();
        imem_req_ready = 1'b0;
        branch_taken = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data = 32'hBAD0_0040;
        step();
        imem_rsp_valid = 1'b0;
        chk_cnt++;
        if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h1000)
            $display("FAIL hs_redirect: iv=%b valid=%b addr=%h want 0/1/00001000", instr_valid, imem_req_valid, imem_req_addr);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        jump = 1'b1;
        jump_target = 32'hFFFF_FFFF;
        step();
        jump = 1'b0;
        chk_cnt++;
        if (imem_req_addr !== 32'hFFFF_FFFC)
            $display("FAIL wrap_setup: addr=%h want fffffffc", imem_req_addr);
        else pass_cnt++;
        fetch_one(32'hFFFF_FFFC, 32'h7777_FFFC);
        e = exp_q.pop_front();
        chk_cnt++;
        if (instr_valid !== 1'b1 || instr !== e.data || instr_pc !== e.pc)
            $display("FAIL wrap_instr: v=%b instr=%h pc=%h want 1/%h/%h", instr_valid, instr, instr_pc, e.data, e.pc);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0)
            $display("FAIL wrap_addr: valid=%b addr=%h want 1/00000000", imem_req_valid, imem_req_addr);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic        pend;
        logic [31:0] exp_pc;
        int          pops;
        int          done_at;
        pend = 1'b0;
        exp_pc = 32'h0;
        pops = 0;
        done_at = -1;
        for (int i = 0; i < 40; i++) begin
            if (instr_valid === 1'b1) begin
                chk_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL b2b_pop%0d: scoreboard empty", pops);
                end else begin
                    e = exp_q.pop_front();
                    if (instr !== e.data || instr_pc !== e.pc)
                        $display("FAIL b2b_instr%0d: instr=%h pc=%h want %h/%h", pops, instr, instr_pc, e.data, e.pc);
                    else pass_cnt++;
                end
                pops++;
                if (pops == 4) begin
                    done_at = i;
                    break;
                end
            end
            imem_rsp_valid = pend;
            if (pend) begin
                imem_rsp_data = exp_pc ^ 32'h5A5A_0000;
                e.pc = exp_pc;
                e.data = exp_pc ^ 32'h5A5A_0000;
                exp_q.push_back(e);
                exp_pc = exp_pc + 32'd4;
            end
            pend = imem_req_valid;
            imem_req_ready = 1'b1;
            step();
        end
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
        chk_cnt++;
        if (done_at != 11)
            $display("FAIL b2b_rate: 4th instr at cycle %0d want 11", done_at);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10)
            $display("FAIL b2b_next: valid=%b addr=%h want 1/00000010", imem_req_valid, imem_req_addr);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        reset = 1'b0;
        step();
        chk_cnt++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0)
            $display("FAIL mid_reset: req_valid=%b iv=%b want 0/0", imem_req_valid, instr_valid);
        else pass_cnt++;
        reset = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data = 32'hBEEF_0010;
        #1;
        chk_cnt++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0)
            $display("FAIL post_reset_req: valid=%b addr=%h want 1/00000000", imem_req_valid, imem_req_addr);
        else pass_cnt++;
        step();
        imem_rsp_valid = 1'b0;
        chk_cnt++;
        if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0)
            $display("FAIL late_rsp: iv=%b valid=%b addr=%h want 0/1/00000000", instr_valid, imem_req_valid, imem_req_addr);
        else pass_cnt++;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_stall();
        test_branch_in_rsp();
        test_redirects();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        chk_cnt++;
        if (exp_q.size() != 0)
            $display("FAIL scoreboard_drain: %0d entries left want 0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch sequencer that drives the program-counter register's input side. It generates the next fetch address (sequential, branch, jump or exception vector) and issues one-at-a-time requests to instruction memory over a valid/ready handshake. It returns each fetched word with its PC to decode, honouring decode stalls and control-flow redirects.

## Interface
- RESET_ADDR, 32'h0000_0000, first fetch address after reset
- EXC_VECTOR, 32'h8000_0180, fetch address on exception
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-low; reset==0 at a rising edge resets the block
- stall  in  1  decode not accepting; holds presented instruction
- branch_taken  in  1  redirect to branch_target (one-cycle pulse)
- branch_target  in  32  branch destination
- jump  in  1  redirect to jump_target (one-cycle pulse)
- jump_target  in  32  jump destination
- exception  in  1  redirect to EXC_VECTOR (one-cycle pulse)
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  32  fetch address
- imem_req_ready  in  1  memory accepts request
- imem_rsp_valid  in  1  read data valid (exactly one per accepted request)
- imem_rsp_data  in  32  instruction word
- instr_valid  out  1  instr/instr_pc valid to decode
- instr  out  32  fetched instruction
- instr_pc  out  32  address of instr

## Operation
- States: REQ, RSP, OUT. Internal registers: pc (current fetch address), kill (discard pending response).
- Reset (reset==0): state=REQ, pc=RESET_ADDR, kill=0; outputs imem_req_valid=0, imem_req_addr=RESET_ADDR, instr_valid=0, instr=0, instr_pc=0.
- REQ: imem_req_valid=1, imem_req_addr=pc. On valid&&ready -> RSP.
- RSP: imem_req_valid=0. On imem_rsp_valid: if kill, discard, clear kill, -> REQ; else register instr=imem_rsp_data, instr_pc=pc, instr_valid=1, -> OUT.
- OUT: instr_valid=1, instr/instr_pc held. If !stall: instr_valid->0, pc=pc+4, -> REQ. If stall: remain.
- Redirect priority: exception > jump > branch_taken. Target has bits [1:0] forced to 0. Effect by state at the redirect cycle:
  - REQ, not handshaking this cycle: pc=target, stay REQ (request address may change since not accepted).
  - REQ, handshaking this cycle: pc=target, kill=1, -> RSP.
  - RSP: pc=target, kill=1; if imem_rsp_valid same cycle, discard that response and -> REQ with kill=0.
  - OUT: instr_valid->0 regardless of stall, pc=target, -> REQ.
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
- imem_rsp_valid in REQ or OUT is a protocol error; ignored.
- Reset mid-operation overrides everything; an in-flight response arriving after reset release in REQ is ignored.

## Timing
- First request: imem_req_valid=1 in the first cycle after reset deasserts, addr=RESET_ADDR.
- Handshake completes on the edge where valid&&ready; addr stable while valid unless redirected.
- instr_valid rises the cycle after imem_rsp_valid.
- With ready=1 and 1-cycle response latency, no stall: one instruction every 3 cycles (REQ, RSP, OUT).
- Redirect seen at edge N: request to target issued no later than the cycle after the killed response returns; from OUT/REQ, target on imem_req_addr in cycle N+1.

## Test plan
- Reset release, ready=1, rsp 1 cycle later with 32'h2000_0001: req addr 0, then instr=32'h2000_0001, instr_pc=0; next req addr 4.
- Stall held 3 cycles in OUT: instr_valid/instr/instr_pc constant; next req addr pc+4 only after stall drops.
- branch_taken with target 32'h0000_0103 while in RSP: returning word discarded (no instr_valid), next req addr 32'h0000_0100.
- exception, jump and branch_taken together in OUT with stall=1: instr_valid drops, next req addr 32'h8000_0180.
- pc at 32'hFFFF_FFFC completes fetch: next req addr 32'h0000_0000.
- reset=0 asserted in RSP: next cycle imem_req_valid=0, instr_valid=0; late rsp ignored; first post-reset req addr RESET_ADDR.
